// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 slave backed by a word-addressed memory, one transaction at a time
module axi_mem_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 2,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int                    IDX_W     = $clog2(MEM_DEPTH);
  localparam int                    NB        = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

  // Next beat address: FIXED holds, INCR steps, WRAP steps inside the aligned wrap window.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [7:0] len,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask;
    step = ADDR_WIDTH'(1) << size;
    mask = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * step - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a + step;
    endcase
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >= MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // Whole-transaction errors decided at grant time.
  function automatic logic grant_err(input logic [1:0] burst, input logic [2:0] size,
                                     input logic [7:0] len);
    return (burst == 2'b11) || (size > 3'd2) ||
           ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;     // 0: write side wins a collision, 1: read side
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;       // grant-time error for the whole burst
  logic                  werr_q, werr_d;     // sticky write error -> SLVERR
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;

  logic                  aw_win, ar_win, aw_rdy, ar_rdy, w_rdy;
  logic                  mem_we, rd_load, rd_err, beat_err;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  unused_sigs;

  assign unused_sigs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

  assign aw_win = s_axi_awvalid && (!s_axi_arvalid || !prio_q);
  assign ar_win = s_axi_arvalid && (!s_axi_awvalid ||  prio_q);

  // Next-state, grants and beat bookkeeping; the read beat register is loaded from the array here.
  always_comb begin
    state_d  = state_q;  prio_d  = prio_q;  id_d    = id_q;    addr_d  = addr_q;
    len_d    = len_q;    size_d  = size_q;  burst_d = burst_q; cnt_d   = cnt_q;
    err_d    = err_q;    werr_d  = werr_q;  rvalid_d = rvalid_q; rdata_d = rdata_q;
    rresp_d  = rresp_q;  rlast_d = rlast_q;
    aw_rdy   = 1'b0;     ar_rdy  = 1'b0;    w_rdy   = 1'b0;    mem_we  = 1'b0;
    rd_load  = 1'b0;     rd_err  = 1'b0;    rd_addr = addr_q;  beat_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aw_win) begin
          aw_rdy  = 1'b1;
          prio_d  = s_axi_arvalid ? 1'b1 : prio_q;
          id_d    = s_axi_awid;   addr_d  = s_axi_awaddr; len_d = s_axi_awlen;
          size_d  = s_axi_awsize; burst_d = s_axi_awburst; cnt_d = 8'd0;
          err_d   = grant_err(s_axi_awburst, s_axi_awsize, s_axi_awlen);
          werr_d  = 1'b0;
          state_d = S_WDATA;
        end else if (ar_win) begin
          ar_rdy  = 1'b1;
          prio_d  = s_axi_awvalid ? 1'b0 : prio_q;
          id_d    = s_axi_arid;   len_d   = s_axi_arlen;
          size_d  = s_axi_arsize; burst_d = s_axi_arburst; cnt_d = 8'd0;
          err_d   = grant_err(s_axi_arburst, s_axi_arsize, s_axi_arlen);
          rd_load = 1'b1;
          rd_addr = s_axi_araddr;
          rd_err  = err_d || out_of_range(s_axi_araddr);
          rlast_d = (s_axi_arlen == 8'd0);
          addr_d  = next_addr(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
          state_d = S_RDATA;
        end
      end
      S_WDATA: begin
        w_rdy = 1'b1;
        if (s_axi_wvalid) begin
          beat_err = err_q || out_of_range(addr_q);
          mem_we   = !beat_err;
          werr_d   = werr_q || beat_err || (s_axi_wlast != (cnt_q == len_q));
          addr_d   = next_addr(addr_q, len_q, size_q, burst_q);
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (s_axi_bready) state_d = S_IDLE;
      end
      S_RDATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0; rlast_d = 1'b0; rdata_d = '0; rresp_d = 2'b00;
            state_d  = S_IDLE;
          end else begin
            rd_load = 1'b1;
            rd_err  = err_q || out_of_range(addr_q);
            rlast_d = ((cnt_q + 8'd1) == len_q);
            cnt_d   = cnt_q + 8'd1;
            addr_d  = next_addr(addr_q, len_q, size_q, burst_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rd_load) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err ? '0 : mem[addr_idx(rd_addr)];
      rresp_d  = rd_err ? 2'b10 : 2'b00;
    end
  end

  // Control and read-beat registers; reset aborts any burst without a response.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE; prio_q <= 1'b0; id_q <= '0; addr_q <= '0; len_q <= '0;
      size_q <= '0; burst_q <= '0; cnt_q <= '0; err_q <= 1'b0; werr_q <= 1'b0;
      rvalid_q <= 1'b0; rdata_q <= '0; rresp_q <= '0; rlast_q <= 1'b0;
    end else begin
      state_q <= state_d; prio_q <= prio_d; id_q <= id_d; addr_q <= addr_d; len_q <= len_d;
      size_q <= size_d; burst_q <= burst_d; cnt_q <= cnt_d; err_q <= err_d; werr_q <= werr_d;
      rvalid_q <= rvalid_d; rdata_q <= rdata_d; rresp_q <= rresp_d; rlast_q <= rlast_d;
    end
  end

  // Byte-strobed array write; contents survive reset.
  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) mem[addr_idx(addr_q)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_awready = aw_rdy && !reset_i;
  assign s_axi_arready = ar_rdy && !reset_i;
  assign s_axi_wready  = w_rdy;
  assign s_axi_bvalid  = (state_q == S_WRESP);
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = (state_q == S_WRESP && werr_q) ? 2'b10 : 2'b00;
  assign s_axi_rid     = id_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - scoreboard bench for axi_mem_slave with a byte-level memory model
module tb_axi_mem_slave;
  localparam int          DEPTH = 1024;
  localparam int          BYTES = DEPTH * 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  awid = '0, arid = '0, bid, rid, bresp, rresp;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic [3:0]  wstrb = '0;
  logic awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic bready = 1'b0, rready = 1'b0;
  logic awready, arready, wready, bvalid, rvalid, rlast;

  axi_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2), .MEM_DEPTH(DEPTH),
                  .BASE_ADDR(BASE)) dut (
    .clock_i(clk), .reset_i(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0),
    .s_axi_awqos(4'h0), .s_axi_awregion(4'h0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0),
    .s_axi_arqos(4'h0), .s_axi_arregion(4'h0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  typedef struct packed { logic [1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct packed { logic [1:0] id; logic [1:0] resp; } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  int          n_tests = 0, n_fail = 0;
  int          rr_mode = 0;
  bit          br_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected response at %0t", name, $time);
  endtask

  function automatic logic [63:0] outs();
    return 64'({awready, arready, wready, bvalid, bresp, bid, rvalid, rdata, rresp, rlast, rid});
  endfunction

  // Address of beat i, straight from the burst definitions.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int i);
    longint step, total, lo;
    step  = longint'(1) << size;
    total = longint'(len + 1) * step;
    if (burst == 0) return a;
    if (burst == 1) return a + 32'(longint'(i) * step);
    lo = (longint'(a) / total) * total;
    return 32'(lo + ((longint'(a) - lo + longint'(i) * step) % total));
  endfunction

  function automatic bit bad_burst(input int len, input int size, input int burst);
    return (burst == 3) || (size > 2) || (burst == 2 && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a - BASE) < 32'(BYTES);
  endfunction

  task automatic model_write(input int id, input logic [31:0] addr, input int len,
                             input int size, input int burst, input bit lastbad);
    bit g, any;
    logic [31:0] a;
    bexp_t e;
    g   = bad_burst(len, size, burst);
    any = g || lastbad;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (g || !in_range(a)) any = 1'b1;
      else begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mdl[int'((a - BASE) >> 2)][8*b +: 8] = wd[i][8*b +: 8];
      end
    end
    e.id = 2'(id);
    e.resp = any ? 2'b10 : 2'b00;
    bq.push_back(e);
  endtask

  task automatic model_read(input int id, input logic [31:0] addr, input int len,
                            input int size, input int burst);
    bit g, err;
    logic [31:0] a;
    rexp_t e;
    g = bad_burst(len, size, burst);
    for (int i = 0; i <= len; i++) begin
      a      = beat_addr(addr, len, size, burst, i);
      err    = g || !in_range(a);
      e.id   = 2'(id);
      e.data = err ? 32'h0 : mdl[int'((a - BASE) >> 2)];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == len);
      rq.push_back(e);
    end
  endtask

  task automatic set_aw(input int id, input logic [31:0] addr, input int len, input int size,
                        input int burst);
    awid = 2'(id); awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
  endtask

  task automatic set_ar(input int id, input logic [31:0] addr, input int len, input int size,
                        input int burst);
    arid = 2'(id); araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
  endtask

  task automatic wait_awready();
    int n = 0;
    @(negedge clk);
    while (!awready && n < 300) begin @(negedge clk); n++; end
    check("aw_grant", 64'(awready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic wait_arready();
    int n = 0;
    @(negedge clk);
    while (!arready && n < 300) begin @(negedge clk); n++; end
    check("ar_grant", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_w(input int len, input bit lastbad);
    int n;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) && !lastbad;
      n = 0;
      @(negedge clk);
      while (!wready && n < 100) begin @(negedge clk); n++; end
      if (!wready) fail_now("w_accept_timeout");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    check("wready_after_last", 64'(wready), 64'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 3000) begin @(posedge clk); n++; end
    check("drain", 64'(rq.size() + bq.size()), 64'd0);
    rq.delete(); bq.delete();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int id, input logic [31:0] addr, input int len, input int size,
                          input int burst, input bit lastbad);
    model_write(id, addr, len, size, burst, lastbad);
    set_aw(id, addr, len, size, burst);
    wait_awready();
    send_w(len, lastbad);
    wait_drain();
  endtask

  task automatic do_read(input int id, input logic [31:0] addr, input int len, input int size,
                         input int burst);
    model_read(id, addr, len, size, burst);
    set_ar(id, addr, len, size, burst);
    wait_arready();
    wait_drain();
  endtask

  // Ready drivers for the response channels.
  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0:       rready = 1'b1;
      1:       rready = !rready;
      default: rready = ($urandom_range(0, 3) != 0);
    endcase
    bready = br_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on every handshake, checks latency and stall stability.
  initial begin : monitor
    rexp_t e;
    bexp_t be;
    logic [34:0] held;
    bit stall, ar_seen;
    stall = 1'b0; ar_seen = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0; ar_seen = 1'b0;
      end else begin
        if (ar_seen) check("r_latency", 64'(rvalid), 64'd1);
        ar_seen = arvalid && arready;
        if (stall) check("r_stable", 64'({rvalid, rdata, rresp, rlast}), 64'({1'b1, held}));
        stall = rvalid && !rready;
        held  = {rdata, rresp, rlast};
        if (rvalid && rready) begin
          if (rq.size() == 0) fail_now("r_unexpected");
          else begin
            e = rq.pop_front();
            check("r_beat", 64'({rid, rdata, rresp, rlast}), 64'(e));
          end
        end
        if (bvalid && bready) begin
          if (bq.size() == 0) fail_now("b_unexpected");
          else begin
            be = bq.pop_front();
            check("b_resp", 64'({bid, bresp}), 64'(be));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    int wl[4];
    int bu, sz, ln, n;
    wl = '{1, 3, 7, 15};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs(), 64'd0);
    @(posedge clk); #1;

    // Collision right after reset: write wins, then read.
    wd[0] = 32'hCAFE0001; ws[0] = 4'hF;
    model_write(1, 32'h300, 0, 2, 1, 1'b0);
    model_read(2, 32'h300, 0, 2, 1);
    set_aw(1, 32'h300, 0, 2, 1); set_ar(2, 32'h300, 0, 2, 1);
    @(negedge clk);
    check("collide1_grants", 64'({awready, arready}), 64'd2);
    @(posedge clk); #1;
    awvalid = 1'b0;
    send_w(0, 1'b0);
    wait_arready();
    wait_drain();

    // Second collision: priority has moved to the read side.
    wd[0] = 32'hCAFE0002; ws[0] = 4'hF;
    model_read(3, 32'h300, 0, 2, 1);
    model_write(0, 32'h304, 0, 2, 1, 1'b0);
    set_aw(0, 32'h304, 0, 2, 1); set_ar(3, 32'h300, 0, 2, 1);
    @(negedge clk);
    check("collide2_grants", 64'({awready, arready}), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_awready();
    send_w(0, 1'b0);
    wait_drain();

    // Fill the whole array with 256-beat bursts, then read the first quarter back.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(k, 32'(k * 1024), 255, 2, 1, 1'b0);
    end
    rr_mode = 2;
    do_read(1, 32'h0, 255, 2, 1);

    // Single beat write/read.
    rr_mode = 0;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(0, 32'h10, 0, 2, 1, 1'b0);
    do_read(0, 32'h10, 0, 2, 1);

    // INCR burst with toggling rready.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(1, 32'h100, 3, 2, 1, 1'b0);
    rr_mode = 1;
    do_read(2, 32'h100, 3, 2, 1);
    rr_mode = 0;

    // WRAP read starting mid-window.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA + 32'(i); ws[i] = 4'hF; end
    do_write(0, 32'h100, 3, 2, 1, 1'b0);
    do_read(0, 32'h108, 3, 2, 2);

    // Strobes and FIXED.
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(0, 32'h20, 0, 2, 1, 1'b0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    do_write(0, 32'h20, 0, 2, 1, 1'b0);
    do_read(0, 32'h20, 0, 2, 1);
    for (int i = 0; i < 3; i++) begin wd[i] = 32'h5000 + 32'(i); ws[i] = 4'hF; end
    do_write(0, 32'h24, 2, 2, 0, 1'b0);
    do_read(0, 32'h24, 0, 2, 1);

    // Errors: out of range, reserved burst, wlast mismatch.
    wd[0] = 32'h0BAD0BAD; ws[0] = 4'hF;
    do_write(0, BASE + 32'(BYTES), 0, 2, 1, 1'b0);
    do_read(0, 32'h0, 0, 2, 1);
    do_read(1, 32'h10, 1, 2, 3);
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(2, 32'h40, 1, 2, 1, 1'b1);
    do_read(2, 32'h40, 1, 2, 1);

    // Randomised traffic under random backpressure.
    rr_mode = 2; br_rand = 1'b1;
    for (int t = 0; t < 60; t++) begin
      n  = $urandom_range(0, 15);
      bu = (n < 4) ? 0 : (n < 10) ? 1 : (n < 15) ? 2 : 3;
      n  = $urandom_range(0, 9);
      sz = (n < 6) ? 2 : (n < 8) ? n - 6 : 3;
      if (bu == 2) ln = ($urandom_range(0, 7) == 0) ? 2 : wl[$urandom_range(0, 3)];
      else         ln = $urandom_range(0, 15);
      a = ($urandom_range(0, 4) == 0) ? 32'hFE0 + 32'($urandom_range(0, 63))
                                      : 32'($urandom_range(0, 4095));
      a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= ln; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
        do_write($urandom_range(0, 3), a, ln, sz, bu, ($urandom_range(0, 7) == 0));
      end else begin
        do_read($urandom_range(0, 3), a, ln, sz, bu);
      end
    end
    rr_mode = 0; br_rand = 1'b0;

    // Reset during beat 2 of an 8-beat read, then a clean transaction.
    model_read(1, 32'h200, 7, 2, 1);
    set_ar(1, 32'h200, 7, 2, 1);
    wait_arready();
    n = 0;
    while (rq.size() > 6 && n < 100) begin @(posedge clk); n++; end
    #1;
    rst = 1'b1;
    rq.delete();
    @(negedge clk);
    check("rvalid_after_reset", 64'(rvalid), 64'd0);
    check("outputs_in_reset", outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wd[0] = 32'h600DF00D; ws[0] = 4'hF;
    do_write(3, 32'h2F0, 0, 2, 1, 1'b0);
    do_read(3, 32'h2F0, 0, 2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 slave (responder) backed by an internal word-addressed memory array.
- Terminates bus-master transactions from the Jtag2Axi or XDMA path, via the crossbar, for bring-up and scratch memory.
- Supports FIXED, INCR and WRAP bursts, narrow transfers and write strobes.
- Serves one transaction at a time, with read/write arbitration.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ID_WIDTH, 2, AXI ID width.
- MEM_DEPTH, 1024, memory depth in 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0, first byte address decoded by this slave.

Ports:
- clock_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address.
- s_axi_awlock/awcache/awprot/awqos/awregion  in  1/4/3/4/4  accepted and ignored.
- s_axi_awvalid in 1; s_axi_awready out 1  write-address handshake.
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data.
- s_axi_wready  out  1  write-data ready.
- s_axi_bid/bresp/bvalid  out  ID_WIDTH/2/1; s_axi_bready  in  1  write response.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address.
- s_axi_arlock/arcache/arprot/arqos/arregion  in  1/4/3/4/4  accepted and ignored.
- s_axi_arvalid in 1; s_axi_arready out 1  read-address handshake.
- s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1; s_axi_rready  in  1  read data.

Behaviour:
- Reset (async assert, sync-safe deassert): all outputs 0, FSM in IDLE, arbitration priority set to write. Memory array is not reset.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - awready/arready are combinational grants, never both high in the same cycle.
  - Only AW valid → grant AW. Only AR valid → grant AR.
  - Both valid → grant the side holding priority; priority then flips to the other side.
  - On grant, latch id, addr, len, size, burst, beat counter = 0.
  - Next state: WDATA for AW, RDATA for AR.
- Error latch at grant (err):
  - burst == 2'b11, or size > 2, or WRAP with len not in {1,3,7,15} → err = 1.
  - Per-beat out of range: (addr − BASE_ADDR) >= MEM_DEPTH*4 → that beat errors.
  - Response is SLVERR (2'b10) if any beat errored, else OKAY.
- WDATA:
  - wready = 1 in this state; one beat accepted per cycle.
  - Beat without error: write bytes where wstrb is set to mem[offset[log2(MEM_DEPTH)+1:2]]. Errored beats are discarded.
  - Advance address per burst rule.
  - Exit on the beat where counter == len → WRESP. wlast is ignored for termination; a wlast mismatch forces SLVERR.
- WRESP:
  - bvalid = 1, bid = latched id, bresp set by the error rules.
  - Hold until bready → IDLE.
- RDATA:
  - Array read registered: first rvalid one cycle after AR handshake.
  - rdata = mem word, or 0 on an errored beat. rresp is per beat. rid = latched id. rlast = 1 on beat len.
  - rvalid/rdata/rresp/rlast held stable while rready = 0.
  - Next beat presented the cycle after rready & rvalid: back-to-back throughput of one beat per cycle.
  - After the rlast handshake → IDLE.
- Address update, step = 1 << size:
  - FIXED: address unchanged.
  - INCR: addr + step.
  - WRAP: wrap_mask = (len+1)*step − 1; next = (addr & ~wrap_mask) | ((addr + step) & wrap_mask).
- Narrow reads return the full aligned word; the master selects byte lanes.
- Boundaries:
  - len = 0 is a single beat.
  - len = 255 gives 256 beats; the counter is 8 bits plus compare.
  - No 4 KB boundary check.
  - New AW/AR is not accepted until the current transaction completes.
- Reset asserted mid-burst: the transaction is aborted immediately and no response is issued.

Test Plan:
- Single write/read:
  - AW addr 0x10, len 0, size 2, wdata 0xDEADBEEF, wstrb 0xF → bresp 0, exactly one wready beat.
  - AR 0x10 → rdata 0xDEADBEEF, rlast = 1, rresp 0, rvalid one cycle after arready.
- INCR burst and backpressure:
  - Write 4 beats at 0x100 with data 1..4, then read len 3 with rready toggling 1,0,1,0.
  - → rdata 1,2,3,4 in order, rdata stable during stall cycles, rlast only on the 4th beat, rid echoes arid = 2'b10.
- WRAP burst:
  - Read len 3, size 2, addr 0x108 after filling 0x100..0x10C with A,B,C,D → rdata C,D,A,B.
- Strobes and FIXED burst:
  - Word 0x20 = 0x11223344; write 0xAABBCCDD with wstrb 0x5 → readback 0x11BB33DD.
  - FIXED burst of 3 writes at 0x24 → last written value retained.
- Errors:
  - Write to BASE_ADDR + MEM_DEPTH*4 → bresp 2'b10, memory unchanged.
  - Read with burst 2'b11, len 1 → two beats with rresp 2'b10, rdata 0.
- Arbitration and reset:
  - AW and AR valid in the same cycle after reset → AW granted first, AR next.
  - Repeat the collision → AR granted first.
  - Assert reset during beat 2 of an 8-beat read → rvalid = 0 next cycle; a fresh transaction then completes with OKAY.
